// File: rtl/encoder4to2_rr.sv
// encoder4to2_rr: sequential 4-to-2 encoder.
// One-hot request pulses collect in a pending register. One 2-bit code per
// pending bit is issued over a valid/ready handshake. Arbitration is
// round-robin (RR_EN=1) or fixed lowest-index-first (RR_EN=0).
module encoder4to2_rr #(
  parameter bit         RR_EN      = 1'b1,
  parameter logic [1:0] RESET_LAST = 2'd3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] req,
  input  logic       ready_i,
  output logic [1:0] code_o,
  output logic       valid_o,
  output logic [3:0] pend_o,
  output logic       multi_o,
  output logic       drop_o
);

  typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

  state_t     state;
  logic [3:0] pend;
  logic [1:0] last;

  logic       fire;
  logic [3:0] clr;
  logic [3:0] next_pend;
  logic [1:0] last_eff;
  logic [1:0] sel;

  // Round-robin pick: scan last+4 (== last) down to last+1 so the
  // highest-priority candidate (last+1) is the final overwrite.
  function automatic logic [1:0] rr_pick(input logic [3:0] p, input logic [1:0] l);
    logic [1:0] idx;
    rr_pick = 2'd0;
    for (int i = 4; i >= 1; i--) begin
      idx = l + 2'(i);
      if (p[idx]) rr_pick = idx;
    end
  endfunction

  // Fixed priority pick: lowest set index wins.
  function automatic logic [1:0] fp_pick(input logic [3:0] p);
    fp_pick = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (p[i]) fp_pick = 2'(i);
    end
  endfunction

  // Handshake, clear mask, merged pending set and next arbitration result.
  // After a fire the pointer used is the code that just fired.
  always_comb begin
    fire      = valid_o & ready_i;
    clr       = fire ? (4'b0001 << code_o) : 4'b0000;
    next_pend = (pend & ~clr) | req;
    last_eff  = fire ? code_o : last;
    sel       = RR_EN ? rr_pick(next_pend, last_eff) : fp_pick(next_pend);
  end

  // Pending register, drop pulse and the IDLE/BUSY handshake FSM.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      pend    <= 4'b0000;
      last    <= RESET_LAST;
      code_o  <= 2'd0;
      valid_o <= 1'b0;
      drop_o  <= 1'b0;
    end else begin
      pend   <= next_pend;
      // A request into a bit that stays pending merges and is flagged.
      drop_o <= |(req & pend & ~clr);
      case (state)
        IDLE: begin
          if (next_pend != 4'b0000) begin
            code_o  <= sel;
            valid_o <= 1'b1;
            state   <= BUSY;
          end
        end
        BUSY: begin
          if (fire) begin
            last <= code_o;
            if (next_pend != 4'b0000) begin
              // back-to-back issue, no bubble
              code_o <= sel;
            end else begin
              code_o  <= 2'd0;
              valid_o <= 1'b0;
              state   <= IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Status decoded purely from the pending register.
  always_comb begin
    pend_o  = pend;
    multi_o = ($countones(pend) >= 2);
  end

endmodule

// File: doc/encoder4to2_rr.md
Name: encoder4to2_rr

Overview:
- Sequential 4-to-2 encoder: the inverse of the team's 2-to-4 one-hot decoder.
- Collects request pulses on 4 one-hot lines into a pending register.
- Emits one 2-bit binary code per request over a valid/ready handshake.
- When several requests are pending, the next code is chosen by round-robin (or fixed priority); feeds the binary-select side of the decoder path.

Parameters:
- RR_EN, 1, 1 = round-robin arbitration; 0 = fixed priority, lowest index wins.
- RESET_LAST, 2'd3, round-robin pointer value after reset, so index 0 has first priority.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- req  input  4  request pulses; bit k requests code k; any number of bits may be set at once.
- ready_i  input  1  consumer accepts code_o this cycle.
- code_o  output  2  binary code of the granted request; registered.
- valid_o  output  1  code_o is valid; registered.
- pend_o  output  4  pending-request register.
- multi_o  output  1  pend_o has 2 or more bits set; decoded from the register, no combinational input path.
- drop_o  output  1  one-cycle pulse: a request merged into an already-pending bit; registered.

Behaviour:
- Reset (asynchronous, any cycle, including mid-handshake): pend=0, valid_o=0, code_o=0, drop_o=0, last=RESET_LAST, state=IDLE. No state survives reset.
- Handshake fire = valid_o & ready_i. clr = onehot(code_o) when fire, else 0.
- next_pend = (pend & ~clr) | req. pend <= next_pend every cycle.
- Set wins over clear: if req[k] arrives in the same cycle bit k is acknowledged, bit k stays pending and is served again later.
- States:
  - IDLE (valid_o=0): if next_pend != 0, load code_o = select(next_pend, last), set valid_o=1, go to BUSY; otherwise stay in IDLE.
  - BUSY (valid_o=1): if !ready_i, code_o and valid_o hold stable; new reqs only accumulate. On fire: last <= code_o. If next_pend != 0, load the next code immediately (back-to-back, no bubble) and stay in BUSY; otherwise clear valid_o and go to IDLE.
- select():
  - RR_EN=1: scan indices (last+1), (last+2), (last+3), (last+4), all mod 4 with wrap-around; first set bit wins.
  - RR_EN=0: lowest set index wins; last is ignored.
  - In BUSY after a fire, select() uses the just-updated last (i.e. the code that fired).
- Latency: req[k] asserted in cycle N → valid_o=1 with code_o=k in cycle N+1, if idle and k wins arbitration. Throughput: 1 code per cycle with ready_i held high.
- code_o is 0 while valid_o=0. It changes only when a new code is loaded.
- drop_o <= |(req & pend & ~clr). Requests are not counted: duplicates merge into one pending bit and raise drop_o.
- Fairness: with RR_EN=1, all 4 bits continuously pending and ready_i=1, each code is granted exactly once in every 4 consecutive fires.

Test Plan:
- Reset: rst=1 for 2 cycles while valid_o=1 and pend=4'b1010 → the same cycle rst asserts, outputs are 0 (valid_o=0, pend_o=0, code_o=0, drop_o=0). First req after release gets code 0 priority.
- Single request: req=4'b0100 for one cycle N, ready_i=1 → cycle N+1: valid_o=1, code_o=2, pend_o=4'b0100, multi_o=0. Cycle N+2: valid_o=0, pend_o=0.
- Burst with round-robin: req=4'b1111 for one cycle, ready_i=1 → code_o=0,1,2,3 on 4 consecutive cycles; pend_o=1111,1110,1100,1000; multi_o=1,1,1,0; then valid_o=0.
- Backpressure: code_o=1 valid, ready_i=0 for 5 cycles, req=4'b1000 pulse during the stall → code_o stays 1 and valid_o stays 1 throughout, pend_o=4'b1010. Raise ready_i → next cycle code_o=3.
- Merge, drop and set-wins: req[1] re-pulsed while pend[1]=1 and not firing → drop_o=1 for exactly one cycle. Separately, req[1] in the same cycle code 1 fires → drop_o=0, pend_o[1] stays 1, code 1 is granted again after the other pending codes.
- Fixed priority (RR_EN=0): pend held at 4'b1001 with repeated req=4'b0001 refreshes, ready_i=1 → code_o=0 on every fire; code 3 is granted only once bit 0 stops being re-requested.
